// File: rtl/neopix_pkg.sv
// +-----------------------------------------------------------------------------
// | neopix_pkg : state encoding and default 50 MHz WS2812 timing for neopix_tx
// | Revision   : 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

package neopix_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BIT   = 2'd1,
        ST_LATCH = 2'd2
    } state_e;

    localparam int DEF_T0H     = 20;
    localparam int DEF_T1H     = 40;
    localparam int DEF_T_BIT   = 63;
    localparam int DEF_T_RESET = 14000;

endpackage

`default_nettype wire

// File: rtl/byte_fifo.sv
// +-----------------------------------------------------------------------------
// | byte_fifo : 8-bit synchronous show-ahead FIFO, wrap-bit full/empty detection
// | Revision  : 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       wr_i,
    input  logic [7:0] wdata_i,
    input  logic       rd_i,
    output logic [7:0] rdata_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]  mem_q [DEPTH];
    logic        do_wr;
    logic        do_rd;

    // Full is judged on current pointers only, so a same-cycle pop never frees room.
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign do_wr   = wr_i && !full_o;
    assign do_rd   = rd_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

`default_nettype wire

// File: rtl/neopix_tx.sv
// +-----------------------------------------------------------------------------
// | neopix_tx : byte stream to WS2812 one-wire serializer with latch insertion
// | Revision  : 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module neopix_tx
    import neopix_pkg::*;
#(
    parameter int T0H        = DEF_T0H,
    parameter int T1H        = DEF_T1H,
    parameter int T_BIT      = DEF_T_BIT,
    parameter int T_RESET    = DEF_T_RESET,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       dout_o,
    output logic       busy_o,
    output logic       overflow_o,
    output logic       frame_done_o
);

    localparam int CW = $clog2(T_BIT);
    localparam int LW = $clog2(T_RESET);
    localparam logic [CW-1:0] C_T0H      = CW'(T0H);
    localparam logic [CW-1:0] C_T1H      = CW'(T1H);
    localparam logic [CW-1:0] C_CYC_LAST = CW'(T_BIT - 1);
    localparam logic [LW-1:0] C_LAT_LAST = LW'(T_RESET - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cyc_cnt_q, cyc_cnt_d;
    logic [LW-1:0] lat_cnt_q, lat_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          dout_q, dout_d;
    logic          overflow_q, overflow_d;
    logic          frame_done_q, frame_done_d;

    logic          fifo_pop;
    logic [7:0]    fifo_rdata;
    logic          fifo_full;
    logic          fifo_empty;

    byte_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .wr_i     (valid_i),
        .wdata_i  (data_i),
        .rd_i     (fifo_pop),
        .rdata_o  (fifo_rdata),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        cyc_cnt_d    = cyc_cnt_q;
        lat_cnt_d    = lat_cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        fifo_pop     = 1'b0;
        dout_d       = 1'b0;
        frame_done_d = 1'b0;
        overflow_d   = valid_i && fifo_full;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shift_d   = fifo_rdata;
                    bit_idx_d = 3'd7;
                    cyc_cnt_d = '0;
                    state_d   = ST_BIT;
                end
            end
            ST_BIT: begin
                dout_d = (cyc_cnt_q < (shift_q[7] ? C_T1H : C_T0H));
                if (cyc_cnt_q == C_CYC_LAST) begin
                    cyc_cnt_d = '0;
                    if (bit_idx_q != 3'd0) begin
                        shift_d   = {shift_q[6:0], 1'b0};
                        bit_idx_d = bit_idx_q - 3'd1;
                    end else if (!fifo_empty) begin
                        // Chain straight into the next byte so there is no gap on the wire.
                        fifo_pop  = 1'b1;
                        shift_d   = fifo_rdata;
                        bit_idx_d = 3'd7;
                    end else begin
                        lat_cnt_d = '0;
                        state_d   = ST_LATCH;
                    end
                end else begin
                    cyc_cnt_d = cyc_cnt_q + 1'b1;
                end
            end
            ST_LATCH: begin
                if (lat_cnt_q == C_LAT_LAST) begin
                    lat_cnt_d    = '0;
                    frame_done_d = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= ST_IDLE;
            cyc_cnt_q    <= '0;
            lat_cnt_q    <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            dout_q       <= 1'b0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cyc_cnt_q    <= cyc_cnt_d;
            lat_cnt_q    <= lat_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            dout_q       <= dout_d;
            overflow_q   <= overflow_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign dout_o       = dout_q;
    assign overflow_o   = overflow_q;
    assign frame_done_o = frame_done_q;
    assign busy_o       = (state_q != ST_IDLE) || !fifo_empty;

endmodule

`default_nettype wire

// File: tb/tb_neopix_tx.sv
// +-----------------------------------------------------------------------------
// | tb_neopix_tx : scoreboard bench decoding the WS2812 line back into bytes
// | Revision     : 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module tb_neopix_tx;

    localparam int T0H     = 2;
    localparam int T1H     = 4;
    localparam int T_BIT   = 6;
    localparam int T_RESET = 10;
    localparam int DEPTH   = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] data = 8'h00;
    logic       valid = 1'b0;
    logic       dout, busy, overflow, frame_done;

    neopix_tx #(
        .T0H(T0H), .T1H(T1H), .T_BIT(T_BIT), .T_RESET(T_RESET), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_i       (clk),
        .reset_n_i   (reset_n),
        .data_i      (data),
        .valid_i     (valid),
        .dout_o      (dout),
        .busy_o      (busy),
        .overflow_o  (overflow),
        .frame_done_o(frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    logic [7:0] exp_q [$];

    // Line decoder / monitor state
    logic       prev_dout = 1'b0;
    int         hi_len = 0, last_hi = 0, since_rise = 0, low_run = 0, nbits = 0;
    bit         in_frame = 1'b0;
    logic [7:0] byte_sr = 8'h00;
    int         fd_cnt = 0, ov_cnt = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_dout = 1'b0; hi_len = 0; since_rise = 0; low_run = 0;
            nbits = 0; in_frame = 1'b0;
        end else begin
            since_rise++;
            if (dout && !prev_dout) begin
                if (in_frame) check_eq("bit_period", since_rise, T_BIT);
                since_rise = 0;
                hi_len = 1;
                low_run = 0;
                in_frame = 1'b1;
            end else if (dout) begin
                hi_len++;
            end else begin
                low_run++;
            end
            if (!dout && prev_dout) begin
                last_hi = hi_len;
                if (hi_len == T1H) byte_sr = {byte_sr[6:0], 1'b1};
                else begin
                    check_eq("high_len", hi_len, T0H);
                    byte_sr = {byte_sr[6:0], 1'b0};
                end
                nbits++;
                if (nbits == 8) begin
                    nbits = 0;
                    check_eq("sb_nonempty", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) check_eq("byte", byte_sr, exp_q.pop_front());
                end
            end
            if (frame_done) begin
                fd_cnt++;
                // Tail of the last bit plus the full latch must be low up to the pulse.
                check_eq("latch_low", low_run, T_BIT - last_hi + T_RESET);
                check_eq("fd_bit_align", nbits, 0);
                in_frame = 1'b0;
            end
            if (overflow) ov_cnt++;
            prev_dout = dout;
        end
    end

    task automatic strobe(input logic [7:0] b, input bit expect_sent);
        @(negedge clk);
        data  = b;
        valid = 1'b1;
        if (expect_sent) exp_q.push_back(b);
    endtask

    task automatic release_strobe();
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (busy && n < budget);
        check_eq(tag, busy, 0);
    endtask

    initial begin
        int fd0, ov0, rises, n;
        logic p, prev_busy;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_dout", dout, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ovf", overflow, 0);
        check_eq("rst_fd", frame_done, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: single byte, latency, latch and busy fall
        fd0 = fd_cnt;
        strobe(8'hA5, 1'b1);
        release_strobe();
        check_eq("lat_n0", dout, 0);
        @(negedge clk); check_eq("lat_n1", dout, 0);
        @(negedge clk); check_eq("lat_n2", dout, 1);
        n = 0; prev_busy = 1'b1;
        do begin
            prev_busy = busy;
            @(negedge clk); #1;
            n++;
        end while (!frame_done && n < 200);
        check_eq("t1_fd_seen", frame_done, 1);
        check_eq("t1_busy_at_fd", busy, 0);
        check_eq("t1_busy_before_fd", prev_busy, 1);
        @(negedge clk); #1;
        check_eq("t1_fd_pulse_width", frame_done, 0);
        check_eq("t1_fd_count", fd_cnt - fd0, 1);

        // 2: back-to-back bytes, no inter-byte gap, single latch
        fd0 = fd_cnt;
        strobe(8'hFF, 1'b1);
        strobe(8'h00, 1'b1);
        strobe(8'h81, 1'b1);
        release_strobe();
        wait_idle("t2_idle", 1000);
        check_eq("t2_fd_count", fd_cnt - fd0, 1);
        check_eq("t2_sb_drained", exp_q.size(), 0);

        // 3: overflow -- six strobes, five fit (one in shift, four in FIFO)
        fd0 = fd_cnt; ov0 = ov_cnt;
        for (int i = 0; i < 6; i++) strobe(8'h11 * (i + 1), i < 5);
        release_strobe();
        wait_idle("t3_idle", 2000);
        check_eq("t3_ovf_count", ov_cnt - ov0, 1);
        check_eq("t3_fd_count", fd_cnt - fd0, 1);
        check_eq("t3_sb_drained", exp_q.size(), 0);

        // 4: byte arriving during the latch must not shorten it
        fd0 = fd_cnt;
        strobe(8'h5A, 1'b1);
        release_strobe();
        n = 0;
        do begin @(negedge clk); #1; n++; end while (exp_q.size() != 0 && n < 200);
        check_eq("t4_first_byte_done", exp_q.size(), 0);
        repeat (T_BIT - T0H + 1) @(negedge clk);
        data = 8'hC3; valid = 1'b1; exp_q.push_back(8'hC3);
        release_strobe();
        wait_idle("t4_idle", 1000);
        check_eq("t4_fd_count", fd_cnt - fd0, 2);
        check_eq("t4_sb_drained", exp_q.size(), 0);

        // 5: asynchronous reset in the middle of the second bit of 0xFF
        fd0 = fd_cnt;
        strobe(8'hFF, 1'b1);
        strobe(8'h12, 1'b1);
        release_strobe();
        rises = 0; p = 1'b0; n = 0;
        while (rises < 2 && n < 100) begin
            @(negedge clk);
            if (dout && !p) rises++;
            p = dout;
            n++;
        end
        check_eq("t5_second_rise", rises, 2);
        repeat (2) @(negedge clk);
        check_eq("t5_high_before_rst", dout, 1);
        #1 reset_n = 1'b0;
        #1;
        check_eq("t5_async_low", dout, 0);
        check_eq("t5_busy_in_rst", busy, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk); #1;
        check_eq("t5_fifo_empty", busy, 0);
        repeat (T_RESET + 3 * T_BIT) @(negedge clk);
        check_eq("t5_no_fd", fd_cnt - fd0, 0);
        strobe(8'h3C, 1'b1);
        release_strobe();
        wait_idle("t5_idle", 1000);
        check_eq("t5_fd_after", fd_cnt - fd0, 1);
        check_eq("t5_sb_drained", exp_q.size(), 0);

        // 6: sustained stream, pointers wrap three times, no starvation
        fd0 = fd_cnt; ov0 = ov_cnt;
        for (int i = 0; i < 12; i++) begin
            strobe(8'($urandom_range(0, 255)), 1'b1);
            release_strobe();
            repeat (6 * T_BIT - 2) @(negedge clk);
        end
        wait_idle("t6_idle", 2000);
        check_eq("t6_ovf_count", ov_cnt - ov0, 0);
        check_eq("t6_fd_count", fd_cnt - fd0, 1);
        check_eq("t6_sb_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/neopix_tx.md
Name: neopix_tx

Overview:
- WS2812/NeoPixel serializer directly downstream of the SPI receive slave.
- Accepts the slave's byte stream (8-bit data plus a one-cycle ready strobe) into a small FIFO.
- Emits each byte MSB-first as WS2812 one-wire pulses on a single output pin.
- Guarantees the reset/latch low time when the stream runs dry.

Parameters:
- T0H, 20: high time of a '0' bit, in clk cycles (0.4 us at 50 MHz).
- T1H, 40: high time of a '1' bit, in clk cycles (0.8 us).
- T_BIT, 63: total bit period, in clk cycles (1.26 us). Constraint: T0H < T1H < T_BIT.
- T_RESET, 14000: latch low time, in clk cycles (280 us).
- FIFO_DEPTH, 16: byte FIFO entries. Must be a power of 2, at least 2.

Ports:
- clk_i, in, 1: system clock.
- reset_n_i, in, 1: asynchronous active-low reset.
- data_i, in, 8: byte from the SPI slave (GRB order, as sent by the host).
- valid_i, in, 1: one-cycle strobe; data_i is valid in this cycle.
- dout_o, out, 1: WS2812 data line, registered.
- busy_o, out, 1: high in any state other than IDLE, or when the FIFO is non-empty.
- overflow_o, out, 1: one-cycle pulse when a byte is dropped because the FIFO is full.
- frame_done_o, out, 1: one-cycle pulse when the latch period completes.

Behaviour:
- Clock and reset: one clock, clk_i. Reset reset_n_i is asynchronous, active-low.
- Reset values:
  - dout_o=0, busy_o=0, overflow_o=0, frame_done_o=0.
  - FIFO empty, state=IDLE, all counters 0.
  - Reset mid-bit aborts immediately: dout_o goes low asynchronously, and FIFO contents are discarded.
- FIFO write:
  - valid_i=1 and not full: data_i is written at that edge.
  - valid_i=1 and full: the byte is dropped and overflow_o pulses on the next cycle.
  - Full is evaluated before the same-cycle pop, so a simultaneous pop does not rescue the write.
- FIFO read: only the FSM pops, in IDLE or at a byte boundary. A write into an empty FIFO is visible to the FSM one cycle later.
- FSM states: IDLE, BIT, LATCH.
- IDLE:
  - If FIFO non-empty: pop into an 8-bit shift register, set bit_idx=7, cyc_cnt=0, go to BIT.
  - Otherwise hold dout_o=0.
- BIT:
  - dout_o = (cyc_cnt < (shift[7] ? T1H : T0H)). cyc_cnt increments every clock.
  - At cyc_cnt==T_BIT-1: cyc_cnt←0.
    - If bit_idx>0: shift left, bit_idx−1.
    - Else if FIFO non-empty: pop the next byte with no gap (the next bit's high starts on the following cycle), bit_idx=7.
    - Else: go to LATCH with lat_cnt=0.
- LATCH:
  - dout_o=0 and lat_cnt increments.
  - At lat_cnt==T_RESET-1: frame_done_o pulses for one cycle and the state returns to IDLE.
  - Bytes arriving during LATCH are queued. They are not sent until IDLE is reached, so the latch is never shortened.
- Latency: with valid_i sampled at edge N, FIFO empty and state IDLE:
  - FSM pops at edge N+1.
  - dout_o rises after edge N+2.
- Underflow mid-frame: if the host starves the FIFO, a latch is inserted (by design). The host must sustain at least 1 byte per 8*T_BIT cycles.
- Counter widths: cyc_cnt is $clog2(T_BIT) bits; lat_cnt is $clog2(T_RESET) bits. Neither counter wraps, because both reset at their terminal count.
- FIFO pointers are $clog2(FIFO_DEPTH)+1 bits wide. Full/empty use MSB-differs/equal wrap detection. Count wrap at FIFO_DEPTH is exercised in test.

Decomposition:
- Package neopix_pkg holds:
  - the state encoding (IDLE, BIT, LATCH);
  - default timing constants for 50 MHz (T0H, T1H, T_BIT, T_RESET).
- Sub-module byte_fifo: synchronous FIFO (8-bit wide, FIFO_DEPTH entries).
  - Ports: clk_i, reset_n_i, wr_i, wdata_i, rd_i, rdata_o, full_o, empty_o.
  - rdata_o is combinational from the read pointer (show-ahead).
- FSM, counters and output register live in neopix_tx.

Test Plan:
Sim parameters: T0H=2, T1H=4, T_BIT=6, T_RESET=10, FIFO_DEPTH=4.
1. Single byte 0xA5 -> dout_o high-run lengths 4,2,4,2,2,4,2,4, each bit period 6 cycles. First rise 2 cycles after valid_i. Then 10 low cycles, then one frame_done_o pulse; busy_o falls the same cycle.
2. Three bytes 0xFF,0x00,0x81 back-to-back, strobed every cycle -> 24 contiguous bit periods with no gap between bytes, then exactly one latch and one frame_done_o.
3. Six strobes in 6 consecutive cycles while IDLE -> 1 popped to shift plus 4 in the FIFO accepted, 1 dropped. Exactly one overflow_o pulse; bytes 1–5 are transmitted in order.
4. New byte strobed at latch cycle 3 -> latch still lasts the full 10 cycles, frame_done_o pulses, then the new byte transmits starting from IDLE.
5. reset_n_i asserted at cycle 3 of the 2nd bit of 0xFF -> dout_o=0 immediately (asynchronous). No frame_done_o. The FIFO is empty after release; the next byte sends normally.
6. 12 bytes fed one at a time at the sustained rate (pointer wrap ×3) -> output matches input order with no overflow and no intermediate latch.
